issue_sched: RTL and testbench

ISSUE_SCHED -- requirements
Module: issue_sched

---
 rtl/issue_sched.sv | 159 +++++++++++++++
 tb/tb_issue_sched.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_sched.sv
// issue_sched: in-order issue stage with a 64-entry pending-write
// scoreboard and memory-pipe drain flushes.
// Ports: clk/rstn (sync, active-low); in_* decoded instruction with
// in_vld/in_rdy handshake; u_*/rf_* registered issue outputs;
// unit_busy (bit0 = IO busy); alu_wb/mem_wb/io_wb writeback addresses.
// Optional macro SCHED_PERF_CNT_EN adds stall_cnt and flush_cnt.
module issue_sched #(
  parameter int MEM_DEPTH = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [5:0]  in_ope,
  input  logic [5:0]  in_rs,
  input  logic [5:0]  in_rt,
  input  logic [5:0]  in_dd,
  input  logic [15:0] in_imm,
  output logic [5:0]  u_ope,
  output logic [5:0]  u_dd,
  output logic [15:0] u_imm,
  output logic [5:0]  rf_rs,
  output logic [5:0]  rf_rt,
  input  logic [6:0]  unit_busy,
  input  logic [5:0]  alu_wb,
  input  logic [5:0]  mem_wb,
  input  logic [5:0]  io_wb
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam int DW =
    (MEM_DEPTH < 1) ? 1 : $clog2(MEM_DEPTH + 1);
  localparam logic [DW-1:0] DRAIN_MAX = DW'(MEM_DEPTH);
  localparam logic [5:0] FLUSH_OPE = 6'b001111;

  logic [63:0]   pend;
  logic [63:0]   pend_nxt;
  logic [63:0]   pend_clr;
  logic [63:0]   pend_set;
  logic [DW-1:0] drain;
  logic [DW-1:0] drain_nxt;

  logic is_nop;
  logic is_mem;
  logic is_ld;
  logic is_io;
  logic is_alu;
  logic wr_dd;
  logic haz;
  logic io_blk;
  logic mem_go;
  logic flush;
  logic issue;
  logic unused_busy;

  assign unused_busy = ^unit_busy[6:1];

  assign is_nop = (in_ope == 6'd0);
  assign is_mem = (in_ope[2:0] == 3'b111);
  assign is_ld  = is_mem & in_ope[3];
  assign is_io  = (in_ope[2:0] == 3'b011);
  assign is_alu = ~is_nop & ~is_mem & ~is_io;
  assign wr_dd  = (is_alu | is_ld | is_io)
                & (in_dd != 6'd0);

  // RAW on both sources plus WAW on the destination,
  // judged only against the registered scoreboard.
  assign haz = pend[in_rs] | pend[in_rt] | pend[in_dd];
  assign io_blk = is_io & unit_busy[0];

  // A MEM op that can go keeps the memory pipe fed, so the
  // flush is only chosen when no such op is on the input.
  assign mem_go = in_vld & is_mem & ~haz;
  assign flush  = rstn & (drain != '0) & ~mem_go;
  assign in_rdy = rstn & ~haz & ~io_blk & ~flush;
  assign issue  = in_vld & in_rdy;

  always_comb begin
    pend_clr = (64'd1 << alu_wb)
             | (64'd1 << mem_wb)
             | (64'd1 << io_wb);
    pend_set = '0;
    if (issue && wr_dd) begin
      pend_set = 64'd1 << in_dd;
    end
    pend_nxt = ((pend & ~pend_clr) | pend_set)
             & ~64'd1;
  end

  always_comb begin
    drain_nxt = drain;
    if (issue && is_ld && (in_dd != 6'd0)) begin
      drain_nxt = DRAIN_MAX;
    end else if ((issue && is_mem) || flush) begin
      if (drain != '0) begin
        drain_nxt = drain - DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend  <= '0;
      drain <= '0;
    end else begin
      pend  <= pend_nxt;
      drain <= drain_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      u_ope <= '0;
      u_dd  <= '0;
      u_imm <= '0;
      rf_rs <= '0;
      rf_rt <= '0;
    end else if (issue) begin
      u_ope <= in_ope;
      u_dd  <= in_dd;
      u_imm <= in_imm;
      rf_rs <= in_rs;
      rf_rt <= in_rt;
    end else if (flush) begin
      u_ope <= FLUSH_OPE;
      u_dd  <= '0;
      u_imm <= '0;
      rf_rs <= '0;
      rf_rt <= '0;
    end else begin
      u_ope <= '0;
      u_dd  <= '0;
      u_imm <= '0;
      rf_rs <= '0;
      rf_rt <= '0;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (in_vld && !in_rdy) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_issue_sched.sv
// tb_issue_sched: directed scenarios plus a randomized run
// against a behavioural scoreboard model of issue_sched.
module tb_issue_sched;

  localparam logic [5:0] OP_ADDI = 6'd1;
  localparam logic [5:0] OP_ADD  = 6'd2;
  localparam logic [5:0] OP_LD   = 6'b011111;
  localparam logic [5:0] OP_ST   = 6'b010111;
  localparam logic [5:0] OP_IN   = 6'b000011;
  localparam logic [5:0] OP_OUT  = 6'b100011;
  localparam logic [5:0] OP_FL   = 6'b001111;
  localparam int K_NOP = 0, K_ALU = 1, K_LD = 2;
  localparam int K_ST = 3, K_IO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_vld;
  logic        in_rdy;
  logic [5:0]  in_ope, in_rs, in_rt, in_dd;
  logic [15:0] in_imm;
  logic [5:0]  u_ope, u_dd, rf_rs, rf_rt;
  logic [15:0] u_imm;
  logic [6:0]  unit_busy;
  logic [5:0]  alu_wb, mem_wb, io_wb;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  issue_sched #(.MEM_DEPTH(3)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_ope    (in_ope),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_dd     (in_dd),
    .in_imm    (in_imm),
    .u_ope     (u_ope),
    .u_dd      (u_dd),
    .u_imm     (u_imm),
    .rf_rs     (rf_rs),
    .rf_rt     (rf_rt),
    .unit_busy (unit_busy),
    .alu_wb    (alu_wb),
    .mem_wb    (mem_wb),
    .io_wb     (io_wb)
`ifdef SCHED_PERF_CNT_EN
    ,.stall_cnt(stall_cnt)
    ,.flush_cnt(flush_cnt)
`endif
  );

  function automatic int kind_of(logic [5:0] op);
    if (op == 6'd0) return K_NOP;
    case (op[2:0])
      3'b111:  return op[3] ? K_LD : K_ST;
      3'b011:  return K_IO;
      default: return K_ALU;
    endcase
  endfunction

  task automatic drv(input logic v, input logic [5:0] op,
                     input logic [5:0] rs, input logic [5:0] rt,
                     input logic [5:0] dd, input logic [15:0] imm);
    in_vld = v; in_ope = op; in_rs = rs;
    in_rt = rt; in_dd = dd; in_imm = imm;
  endtask

  task automatic idle();
    drv(1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 16'd0);
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    unit_busy = '0; alu_wb = '0; mem_wb = '0; io_wb = '0;
    rstn = 1'b0;
    edge1();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    unit_busy = '0; alu_wb = '0; mem_wb = '0; io_wb = '0;
    drv(1'b1, OP_ADDI, 6'd1, 6'd2, 6'd3, 16'h0055);
    @(negedge clk);
    checks++; if (in_rdy !== 1'b0) $display("FAIL rst_rdy got %b want 0", in_rdy); else passed++;
    edge1();
    checks++;
    if ({u_ope, u_dd, u_imm, rf_rs, rf_rt} !== 40'd0)
      $display("FAIL rst_out got %h want 0", {u_ope, u_dd, u_imm, rf_rs, rf_rt});
    else passed++;
`ifdef SCHED_PERF_CNT_EN
    checks++;
    if ({stall_cnt, flush_cnt} !== 48'd0)
      $display("FAIL rst_cnt got %h want 0", {stall_cnt, flush_cnt});
    else passed++;
`endif
    rstn = 1'b1;
    idle();
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) $display("FAIL rst_idle_rdy got %b want 1", in_rdy); else passed++;
    edge1();
    checks++; if (u_ope !== 6'd0) $display("FAIL rst_idle_ope got %h want 0", u_ope); else passed++;
  endtask

  task automatic test_raw();
    do_reset();
    drv(1'b1, OP_ADDI, 6'd0, 6'd0, 6'd5, 16'h0011);
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) $display("FAIL raw_addi_rdy got %b want 1", in_rdy); else passed++;
    edge1();
    checks++;
    if ({u_ope, u_dd, u_imm} !== {OP_ADDI, 6'd5, 16'h0011})
      $display("FAIL raw_addi_out got %h want %h", {u_ope, u_dd, u_imm}, {OP_ADDI, 6'd5, 16'h0011});
    else passed++;
    drv(1'b1, OP_ADD, 6'd5, 6'd0, 6'd6, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) alu_wb = 6'd5;
      @(negedge clk);
      checks++; if (in_rdy !== 1'b0) $display("FAIL raw_stall%0d got %b want 0", i, in_rdy); else passed++;
      edge1();
      checks++; if (u_ope !== 6'd0) $display("FAIL raw_nop%0d got %h want 0", i, u_ope); else passed++;
    end
    alu_wb = 6'd0;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) $display("FAIL raw_release got %b want 1", in_rdy); else passed++;
    edge1();
    checks++;
    if ({u_ope, u_dd, rf_rs} !== {OP_ADD, 6'd6, 6'd5})
      $display("FAIL raw_add_out got %h want %h", {u_ope, u_dd, rf_rs}, {OP_ADD, 6'd6, 6'd5});
    else passed++;
    idle();
  endtask

  task automatic test_load_flush();
    do_reset();
    drv(1'b1, OP_LD, 6'd1, 6'd0, 6'd7, 16'h0004);
    edge1();
    checks++;
    if ({u_ope, u_dd} !== {OP_LD, 6'd7})
      $display("FAIL lf_load got %h want %h", {u_ope, u_dd}, {OP_LD, 6'd7});
    else passed++;
    drv(1'b1, OP_ADDI, 6'd3, 6'd0, 6'd2, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (in_rdy !== 1'b0) $display("FAIL lf_rdy%0d got %b want 0", i, in_rdy); else passed++;
      edge1();
      checks++;
      if ({u_ope, u_dd} !== {OP_FL, 6'd0})
        $display("FAIL lf_flush%0d got %h want %h", i, {u_ope, u_dd}, {OP_FL, 6'd0});
      else passed++;
    end
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) $display("FAIL lf_alu_rdy got %b want 1", in_rdy); else passed++;
    edge1();
    checks++;
    if ({u_ope, u_dd} !== {OP_ADDI, 6'd2})
      $display("FAIL lf_alu got %h want %h", {u_ope, u_dd}, {OP_ADDI, 6'd2});
    else passed++;
    drv(1'b1, OP_ADD, 6'd7, 6'd0, 6'd8, 16'h0000);
    mem_wb = 6'd7;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b0) $display("FAIL lf_r7_busy got %b want 0", in_rdy); else passed++;
    edge1();
    mem_wb = 6'd0;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) $display("FAIL lf_r7_free got %b want 1", in_rdy); else passed++;
    edge1();
    idle();
`ifdef SCHED_PERF_CNT_EN
    checks++; if (flush_cnt !== 16'd3) $display("FAIL lf_flush_cnt got %0d want 3", flush_cnt); else passed++;
`endif
  endtask

  task automatic test_load_stores();
    do_reset();
    drv(1'b1, OP_LD, 6'd1, 6'd0, 6'd7, 16'h0008);
    edge1();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, OP_ST, 6'd1, 6'd2, 6'd0, 16'(i));
      @(negedge clk);
      checks++; if (in_rdy !== 1'b1) $display("FAIL ls_st_rdy%0d got %b want 1", i, in_rdy); else passed++;
      edge1();
      checks++;
      if ({u_ope, u_dd} !== {OP_ST, 6'd0})
        $display("FAIL ls_st%0d got %h want %h", i, {u_ope, u_dd}, {OP_ST, 6'd0});
      else passed++;
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      edge1();
      checks++; if (u_ope !== 6'd0) $display("FAIL ls_noflush%0d got %h want 0", i, u_ope); else passed++;
    end
`ifdef SCHED_PERF_CNT_EN
    checks++; if (flush_cnt !== 16'd0) $display("FAIL ls_flush_cnt got %0d want 0", flush_cnt); else passed++;
`endif
  endtask

  task automatic test_io();
    do_reset();
    drv(1'b1, OP_IN, 6'd0, 6'd0, 6'd9, 16'h0002);
    edge1();
    checks++;
    if ({u_ope, u_dd} !== {OP_IN, 6'd9})
      $display("FAIL io_in got %h want %h", {u_ope, u_dd}, {OP_IN, 6'd9});
    else passed++;
    unit_busy = 7'b0000001;
    drv(1'b1, OP_OUT, 6'd1, 6'd0, 6'd0, 16'h0003);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (in_rdy !== 1'b0) $display("FAIL io_out_stall%0d got %b want 0", i, in_rdy); else passed++;
      edge1();
    end
    drv(1'b1, OP_ADDI, 6'd2, 6'd0, 6'd3, 16'h0007);
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) $display("FAIL io_alu_rdy got %b want 1", in_rdy); else passed++;
    edge1();
    checks++;
    if ({u_ope, u_dd} !== {OP_ADDI, 6'd3})
      $display("FAIL io_alu got %h want %h", {u_ope, u_dd}, {OP_ADDI, 6'd3});
    else passed++;
    unit_busy = '0;
    drv(1'b1, OP_OUT, 6'd1, 6'd0, 6'd0, 16'h0003);
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) $display("FAIL io_out_free got %b want 1", in_rdy); else passed++;
    edge1();
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    drv(1'b1, OP_LD, 6'd1, 6'd0, 6'd7, 16'h0000);
    edge1();
    idle();
    edge1();
    checks++; if (u_ope !== OP_FL) $display("FAIL rm_flush got %h want %h", u_ope, OP_FL); else passed++;
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b0) $display("FAIL rm_rst_rdy got %b want 0", in_rdy); else passed++;
    edge1();
    checks++; if (u_ope !== 6'd0) $display("FAIL rm_rst_ope got %h want 0", u_ope); else passed++;
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) $display("FAIL rm_noflush_rdy got %b want 1", in_rdy); else passed++;
    edge1();
    checks++; if (u_ope !== 6'd0) $display("FAIL rm_noflush got %h want 0", u_ope); else passed++;
    drv(1'b1, OP_ADD, 6'd7, 6'd0, 6'd1, 16'h0000);
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) $display("FAIL rm_sb_clear got %b want 1", in_rdy); else passed++;
    edge1();
    idle();
  endtask

  task automatic test_dual_wb();
    do_reset();
    drv(1'b1, OP_ADDI, 6'd0, 6'd0, 6'd3, 16'h0001);
    edge1();
    drv(1'b1, OP_LD, 6'd1, 6'd0, 6'd4, 16'h0000);
    edge1();
    idle();
    repeat (3) edge1();
    drv(1'b1, OP_ADD, 6'd3, 6'd4, 6'd5, 16'h0000);
    alu_wb = 6'd3;
    mem_wb = 6'd4;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b0) $display("FAIL dw_same_cycle got %b want 0", in_rdy); else passed++;
    edge1();
    alu_wb = 6'd0;
    mem_wb = 6'd0;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1) $display("FAIL dw_both_clear got %b want 1", in_rdy); else passed++;
    edge1();
    checks++;
    if ({u_ope, u_dd} !== {OP_ADD, 6'd5})
      $display("FAIL dw_issue got %h want %h", {u_ope, u_dd}, {OP_ADD, 6'd5});
    else passed++;
    idle();
  endtask

  task automatic test_random();
    bit   mpend[int];
    int   keys[$];
    int   mdrain = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    bit   hold = 0;
    int   kind, k;
    logic [5:0] tmp;
    bit   haz, ememgo, eflush, erdy, eiss;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        in_vld = ($urandom_range(0, 3) != 0);
        k = $urandom_range(0, 7);
        tmp = 6'($urandom);
        case (k)
          0: in_ope = 6'd0;
          4: in_ope = {tmp[5:4], 4'b1111};
          5: in_ope = {tmp[5:4], 4'b0111};
          6, 7: in_ope = {tmp[5:3], 3'b011};
          default: begin
            do in_ope = 6'($urandom);
            while (in_ope == 6'd0 || in_ope[2:0] == 3'b111
                   || in_ope[2:0] == 3'b011);
          end
        endcase
        in_rs = 6'($urandom_range(0, 7));
        in_rt = 6'($urandom_range(0, 7));
        in_dd = 6'($urandom_range(0, 7));
        in_imm = 16'($urandom);
      end
      unit_busy = 7'($urandom);
      keys.delete();
      foreach (mpend[r]) keys.push_back(r);
      alu_wb = (keys.size() > 0 && $urandom_range(0, 2) == 0)
             ? 6'(keys[$urandom_range(0, keys.size() - 1)]) : 6'd0;
      mem_wb = (keys.size() > 0 && $urandom_range(0, 2) == 0)
             ? 6'(keys[$urandom_range(0, keys.size() - 1)]) : 6'd0;
      io_wb = (keys.size() > 0 && $urandom_range(0, 2) == 0)
            ? 6'(keys[$urandom_range(0, keys.size() - 1)]) : 6'd0;
      kind = kind_of(in_ope);
      haz = mpend.exists(int'(in_rs)) || mpend.exists(int'(in_rt))
         || mpend.exists(int'(in_dd));
      ememgo = in_vld && (kind == K_LD || kind == K_ST) && !haz;
      eflush = (mdrain > 0) && !ememgo;
      erdy = !haz && !(kind == K_IO && unit_busy[0]) && !eflush;
      eiss = in_vld && erdy;
      @(negedge clk);
      checks++;
      if (in_rdy !== erdy) $display("FAIL rnd_rdy c%0d got %b want %b", i, in_rdy, erdy);
      else passed++;
      edge1();
      checks++;
      if (eiss) begin
        if ({u_ope, u_dd, u_imm, rf_rs, rf_rt} !== {in_ope, in_dd, in_imm, in_rs, in_rt})
          $display("FAIL rnd_issue c%0d got %h want %h", i,
                   {u_ope, u_dd, u_imm, rf_rs, rf_rt}, {in_ope, in_dd, in_imm, in_rs, in_rt});
        else passed++;
      end else if (eflush) begin
        if ({u_ope, u_dd, u_imm, rf_rs, rf_rt} !== {OP_FL, 34'd0})
          $display("FAIL rnd_flush c%0d got %h want %h", i,
                   {u_ope, u_dd, u_imm, rf_rs, rf_rt}, {OP_FL, 34'd0});
        else passed++;
      end else begin
        if ({u_ope, u_dd} !== 12'd0)
          $display("FAIL rnd_nop c%0d got %h want 0", i, {u_ope, u_dd});
        else passed++;
      end
      if (alu_wb != 0) mpend.delete(int'(alu_wb));
      if (mem_wb != 0) mpend.delete(int'(mem_wb));
      if (io_wb != 0) mpend.delete(int'(io_wb));
      if (eiss && in_dd != 0 && (kind == K_ALU || kind == K_LD || kind == K_IO))
        mpend[int'(in_dd)] = 1'b1;
      if (eiss && kind == K_LD && in_dd != 0) mdrain = 3;
      else if ((eiss && (kind == K_LD || kind == K_ST)) || eflush)
        mdrain = (mdrain > 0) ? mdrain - 1 : 0;
      if (in_vld && !erdy) m_stall++;
      if (eflush) m_flush++;
      hold = in_vld && !erdy;
    end
    idle();
    alu_wb = '0; mem_wb = '0; io_wb = '0;
`ifdef SCHED_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 32'(m_stall)) $display("FAIL rnd_stall_cnt got %0d want %0d", stall_cnt, m_stall);
    else passed++;
    checks++;
    if (flush_cnt !== 16'(m_flush)) $display("FAIL rnd_flush_cnt got %0d want %0d", flush_cnt, m_flush);
    else passed++;
`endif
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    unit_busy = '0; alu_wb = '0; mem_wb = '0; io_wb = '0;
    #2;
    test_reset();
    test_raw();
    test_load_flush();
    test_load_stores();
    test_io();
    test_reset_mid();
    test_dual_wb();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
